// File: rtl/pcm_to_i2s_transmitter_pkg.sv
// Shared definitions for the I2S transmitter/receiver pair: run-state encoding
// and the default PCM word width.
package pcm_to_i2s_transmitter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEFAULT_NUMBER_OF_BITS = 8;

endpackage

// File: rtl/i2s_sck_gen.sv
// I2S bit-clock generator: divides clk by 2*CLK_DIV and flags the clk in which
// sck falls, so the frame logic can update sd/ws together with that edge.
module i2s_sck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic sck,
    output logic fall_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          terminal;

    assign terminal  = (cnt == CW'(CLK_DIV - 1));
    assign fall_tick = run && terminal && sck;

    // Held at count 0 with sck low while stopped, so the first rising edge
    // lands exactly CLK_DIV clks after the run request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (!run) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (terminal) begin
            cnt <= '0;
            sck <= ~sck;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/pcm_to_i2s_transmitter.sv
// I2S transmitter: one-deep sample holding register, frame position counter and
// a whole-frame shift register whose MSB drives sd directly.
module pcm_to_i2s_transmitter
    import pcm_to_i2s_transmitter_pkg::*;
#(
    parameter int NUMBER_OF_BITS = DEFAULT_NUMBER_OF_BITS,
    parameter int SLOT_BITS      = 16,
    parameter int CLK_DIV        = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [NUMBER_OF_BITS-1:0] data_left_input,
    input  logic [NUMBER_OF_BITS-1:0] data_right_input,
    input  logic                      sample_valid,
    output logic                      sample_ready,
    output logic                      sck,
    output logic                      ws,
    output logic                      sd,
    output logic                      underrun,
    output logic                      busy
);

    localparam int FB   = 2 * SLOT_BITS;
    localparam int PW   = $clog2(FB);
    localparam int LAST = FB - 1;

    // Valid/ready: a pair transfers on any clk edge where sample_valid and
    // sample_ready are both high; sample_valid must not wait for sample_ready.

    state_t                    state;
    logic [PW-1:0]             pos;
    logic [FB-1:0]             frame_sh;
    logic [NUMBER_OF_BITS-1:0] hold_left;
    logic [NUMBER_OF_BITS-1:0] hold_right;
    logic                      hold_full;
    logic                      hold_full_nxt;
    logic [FB-1:0]             load_word;
    logic                      running;
    logic                      tick;
    logic                      frame_end;
    logic                      frame_start;
    logic                      handshake;

    function automatic logic ws_at(input int np);
        return (np >= SLOT_BITS - 1) && (np <= FB - 2);
    endfunction

    assign running     = (state == RUN);
    assign busy        = running;
    assign sd          = frame_sh[FB-1];
    assign handshake   = sample_valid && sample_ready;
    assign frame_end   = running && tick && (pos == PW'(LAST));
    assign frame_start = (!running && enable) || (frame_end && enable);

    i2s_sck_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sck_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (running),
        .sck      (sck),
        .fall_tick(tick)
    );

    // Each word sits MSB-first at the top of its slot, zero padded below.
    always_comb begin
        load_word = '0;
        if (hold_full) begin
            load_word = (FB'(hold_left) << (FB - NUMBER_OF_BITS))
                      | (FB'(hold_right) << (SLOT_BITS - NUMBER_OF_BITS));
        end
    end

    // A frame start drains holding before a same-clk handshake refills it.
    always_comb begin
        hold_full_nxt = hold_full;
        if (frame_start) hold_full_nxt = 1'b0;
        if (handshake)   hold_full_nxt = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pos          <= '0;
            frame_sh     <= '0;
            ws           <= 1'b0;
            underrun     <= 1'b0;
            sample_ready <= 1'b0;
            hold_full    <= 1'b0;
            hold_left    <= '0;
            hold_right   <= '0;
        end else begin
            underrun     <= frame_start && !hold_full;
            sample_ready <= enable && !hold_full_nxt;
            hold_full    <= hold_full_nxt;
            if (handshake) begin
                hold_left  <= data_left_input;
                hold_right <= data_right_input;
            end
            case (state)
                IDLE: begin
                    if (enable) begin
                        state    <= RUN;
                        pos      <= '0;
                        frame_sh <= load_word;
                        ws       <= ws_at(0);
                    end
                end
                RUN: begin
                    if (tick) begin
                        if (frame_end) begin
                            pos <= '0;
                            if (enable) begin
                                frame_sh <= load_word;
                                ws       <= ws_at(0);
                            end else begin
                                state    <= IDLE;
                                frame_sh <= '0;
                                ws       <= 1'b0;
                            end
                        end else begin
                            pos      <= pos + PW'(1);
                            frame_sh <= frame_sh << 1;
                            ws       <= ws_at(int'(pos) + 1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pcm_to_i2s_transmitter.sv
// Self-checking bench for pcm_to_i2s_transmitter: a monitor records (ws, sd) at
// every sck rising edge and frames are compared against an arithmetic model.
module tb_pcm_to_i2s_transmitter;

    localparam int N  = 8;
    localparam int S  = 16;
    localparam int D  = 2;
    localparam int FB = 2 * S;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b0;
    logic [N-1:0] dl = '0;
    logic [N-1:0] dr = '0;
    logic         sample_valid = 1'b0;
    logic         sample_ready;
    logic         sck;
    logic         ws;
    logic         sd;
    logic         underrun;
    logic         busy;

    int checks = 0;
    int passes = 0;

    logic [1:0]     rx_q[$];
    logic [2*N-1:0] exp_q[$];
    int             under_cnt = 0;
    logic           prev_sck = 1'b0;

    always #5 clk = ~clk;

    pcm_to_i2s_transmitter #(
        .NUMBER_OF_BITS(N),
        .SLOT_BITS     (S),
        .CLK_DIV       (D)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .data_left_input (dl),
        .data_right_input(dr),
        .sample_valid    (sample_valid),
        .sample_ready    (sample_ready),
        .sck             (sck),
        .ws              (ws),
        .sd              (sd),
        .underrun        (underrun),
        .busy            (busy)
    );

    // Receiver view: capture ws/sd on every sck rise, count underrun pulses.
    always @(negedge clk) begin
        if (!rst_n) begin
            rx_q.delete();
            under_cnt = 0;
            prev_sck  = 1'b0;
        end else begin
            if (sck && !prev_sck) rx_q.push_back({ws, sd});
            if (underrun) under_cnt = under_cnt + 1;
            prev_sck = sck;
        end
    end

    // Expected frame: position p carries bit N-1-q of the slot word while
    // q < N, else 0; ws is high for p in [S-1, 2S-2].
    function automatic void model_frame(input logic [N-1:0] l, input logic [N-1:0] r,
                                        output logic [FB-1:0] sdv, output logic [FB-1:0] wsv);
        for (int p = 0; p < FB; p++) begin
            int q;
            q = p % S;
            if (q < N) sdv[p] = (p < S) ? l[N-1-q] : r[N-1-q];
            else       sdv[p] = 1'b0;
            wsv[p] = (p >= S - 1) && (p <= 2 * S - 2);
        end
    endfunction

    function automatic void rx_frame(input int k, output logic [FB-1:0] sdv,
                                     output logic [FB-1:0] wsv);
        for (int p = 0; p < FB; p++) begin
            int idx;
            idx = k * FB + p;
            if (idx < rx_q.size()) {wsv[p], sdv[p]} = rx_q[idx];
            else                   {wsv[p], sdv[p]} = 2'bxx;
        end
    endfunction

    task automatic do_reset();
        rst_n        = 1'b0;
        enable       = 1'b0;
        sample_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_rx(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (rx_q.size() >= n) ok = 1'b1;
        end
    endtask

    task automatic push_pair(input logic [N-1:0] l, input logic [N-1:0] r, output bit ok);
        dl           = l;
        dr           = r;
        sample_valid = 1'b1;
        ok           = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (sample_ready) begin
                ok = 1'b1;
                @(posedge clk);
                #1;
            end
        end
        sample_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({sck, ws, sd, sample_ready, underrun, busy} !== 6'b0) begin
            $display("FAIL reset_async_outputs got %b want 000000",
                     {sck, ws, sd, sample_ready, underrun, busy});
        end else passes++;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({sck, ws, sd, sample_ready, underrun, busy} !== 6'b0) begin
            $display("FAIL reset_held_with_enable got %b want 000000",
                     {sck, ws, sd, sample_ready, underrun, busy});
        end else passes++;
        enable = 1'b0;
    endtask

    task automatic test_known_pair();
        bit ok;
        logic [FB-1:0] es, ew, gs, gw;
        do_reset();
        enable = 1'b1;
        push_pair(8'hA5, 8'h3C, ok);
        checks++;
        if (!ok) $display("FAIL known_handshake got timeout want accepted");
        else passes++;
        wait_rx(2 * FB, ok);
        checks++;
        if (!ok) $display("FAIL known_rx got %0d bits want %0d", rx_q.size(), 2 * FB);
        else passes++;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) model_frame('0, '0, es, ew);
            else        model_frame(8'hA5, 8'h3C, es, ew);
            rx_frame(k, gs, gw);
            checks++;
            if (gs !== es) $display("FAIL known_sd frame %0d got %h want %h", k, gs, es);
            else passes++;
            checks++;
            if (gw !== ew) $display("FAIL known_ws frame %0d got %h want %h", k, gw, ew);
            else passes++;
        end
        checks++;
        if (under_cnt !== 1) $display("FAIL known_underrun got %0d want 1", under_cnt);
        else passes++;
        enable = 1'b0;
    endtask

    task automatic test_underrun();
        bit ok;
        logic [FB-1:0] es, ew, gs, gw;
        do_reset();
        enable = 1'b1;
        wait_rx(3 * FB, ok);
        checks++;
        if (!ok) $display("FAIL underrun_rx got %0d bits want %0d", rx_q.size(), 3 * FB);
        else passes++;
        checks++;
        if (under_cnt !== 3) $display("FAIL underrun_count got %0d want 3", under_cnt);
        else passes++;
        model_frame('0, '0, es, ew);
        for (int k = 0; k < 3; k++) begin
            rx_frame(k, gs, gw);
            checks++;
            if ({gs, gw} !== {es, ew}) begin
                $display("FAIL underrun_frame %0d got sd=%h ws=%h want sd=%h ws=%h",
                         k, gs, gw, es, ew);
            end else passes++;
        end
        enable = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit pend;
        int k;
        int ready_cycles;
        int unsigned base;
        logic [FB-1:0] es, ew, gs, gw;
        do_reset();
        exp_q.delete();
        base         = $urandom;
        k            = 0;
        pend         = 1'b0;
        ready_cycles = 0;
        dl           = N'(base);
        dr           = N'(base + 1);
        enable       = 1'b1;
        sample_valid = 1'b1;
        for (int i = 0; i < 4 * 4 * S * D; i++) begin
            @(negedge clk);
            if (pend) begin
                k++;
                dl   = N'(base + 2 * k);
                dr   = N'(base + 2 * k + 1);
                pend = 1'b0;
            end
            if (sample_ready) begin
                ready_cycles++;
                exp_q.push_back({dl, dr});
                pend = 1'b1;
            end
        end
        sample_valid = 1'b0;
        wait_rx(4 * FB, ok);
        checks++;
        if (ready_cycles !== 4) $display("FAIL stream_ready_cycles got %0d want 4", ready_cycles);
        else passes++;
        checks++;
        if (under_cnt !== 1) $display("FAIL stream_underrun got %0d want 1", under_cnt);
        else passes++;
        for (int f = 0; f < 4; f++) begin
            if (f == 0)                model_frame('0, '0, es, ew);
            else if (f - 1 < exp_q.size()) model_frame(exp_q[f-1][2*N-1:N], exp_q[f-1][N-1:0], es, ew);
            else                       begin es = 'x; ew = 'x; end
            rx_frame(f, gs, gw);
            checks++;
            if ({gs, gw} !== {es, ew}) begin
                $display("FAIL stream_frame %0d got sd=%h ws=%h want sd=%h ws=%h",
                         f, gs, gw, es, ew);
            end else passes++;
        end
        enable = 1'b0;
    endtask

    task automatic test_stop_restart();
        bit ok;
        logic [N-1:0] al, ar, bl, br;
        logic [FB-1:0] es, ew, gs, gw;
        do_reset();
        al = N'($urandom); ar = N'($urandom);
        bl = N'($urandom); br = N'($urandom);
        enable = 1'b1;
        push_pair(al, ar, ok);
        push_pair(bl, br, ok);
        checks++;
        if (!ok) $display("FAIL stop_handshake got timeout want accepted");
        else passes++;
        wait_rx(FB + 6, ok);
        enable = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
        end
        checks++;
        if (rx_q.size() !== 2 * FB) $display("FAIL stop_frame_completed got %0d bits want %0d",
                                             rx_q.size(), 2 * FB);
        else passes++;
        repeat ($urandom_range(3, 20)) @(negedge clk);
        checks++;
        if ({busy, sck, ws, sd, sample_ready} !== 5'b0 || rx_q.size() !== 2 * FB) begin
            $display("FAIL stop_idle got busy/sck/ws/sd/ready=%b bits=%0d want 00000 bits=%0d",
                     {busy, sck, ws, sd, sample_ready}, rx_q.size(), 2 * FB);
        end else passes++;
        enable = 1'b1;
        wait_rx(3 * FB, ok);
        for (int f = 0; f < 3; f++) begin
            if (f == 0)      model_frame('0, '0, es, ew);
            else if (f == 1) model_frame(al, ar, es, ew);
            else             model_frame(bl, br, es, ew);
            rx_frame(f, gs, gw);
            checks++;
            if ({gs, gw} !== {es, ew}) begin
                $display("FAIL stop_frame %0d got sd=%h ws=%h want sd=%h ws=%h",
                         f, gs, gw, es, ew);
            end else passes++;
        end
        checks++;
        if (under_cnt !== 1) $display("FAIL stop_underrun got %0d want 1", under_cnt);
        else passes++;
        enable = 1'b0;
    endtask

    task automatic test_coincident();
        bit ok;
        logic [N-1:0] cl, cr;
        logic [FB-1:0] es, ew, gs, gw;
        do_reset();
        cl = N'($urandom); cr = N'($urandom);
        enable = 1'b1;
        repeat (4 * S * D) @(negedge clk);
        dl = cl;
        dr = cr;
        sample_valid = 1'b1;
        checks++;
        if (sample_ready !== 1'b1) $display("FAIL coinc_ready got %b want 1", sample_ready);
        else passes++;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        wait_rx(3 * FB, ok);
        checks++;
        if (under_cnt !== 2) $display("FAIL coinc_underrun got %0d want 2", under_cnt);
        else passes++;
        for (int f = 0; f < 3; f++) begin
            if (f < 2) model_frame('0, '0, es, ew);
            else       model_frame(cl, cr, es, ew);
            rx_frame(f, gs, gw);
            checks++;
            if ({gs, gw} !== {es, ew}) begin
                $display("FAIL coinc_frame %0d got sd=%h ws=%h want sd=%h ws=%h",
                         f, gs, gw, es, ew);
            end else passes++;
        end
        enable = 1'b0;
    endtask

    task automatic test_async_reset();
        bit ok;
        logic [FB-1:0] es, ew, gs, gw;
        do_reset();
        enable = 1'b1;
        push_pair(N'($urandom), N'($urandom), ok);
        push_pair(N'($urandom), N'($urandom), ok);
        wait_rx(FB + 21, ok);
        #1;
        checks++;
        if ({busy, ws} !== 2'b11) $display("FAIL areset_pre got busy/ws=%b want 11", {busy, ws});
        else passes++;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({sck, ws, sd, sample_ready, busy} !== 5'b0) begin
            $display("FAIL areset_outputs got sck/ws/sd/ready/busy=%b want 00000",
                     {sck, ws, sd, sample_ready, busy});
        end else passes++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_rx(FB, ok);
        model_frame('0, '0, es, ew);
        rx_frame(0, gs, gw);
        checks++;
        if ({gs, gw} !== {es, ew}) begin
            $display("FAIL areset_restart got sd=%h ws=%h want sd=%h ws=%h", gs, gw, es, ew);
        end else passes++;
        checks++;
        if (under_cnt !== 1) $display("FAIL areset_underrun got %0d want 1", under_cnt);
        else passes++;
        enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_known_pair();
        test_underrun();
        test_back_to_back();
        test_stop_restart();
        test_coincident();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
